// File: rtl/multi_ball_hit_controller.sv
// Multi-ball hit controller: gathers per-ball hit evidence while a frame is
// scanned, snapshots it at startOfFrame, then resolves one ball per cycle
// (hole > ball-ball > border > none) and publishes the results with a
// one-cycle resultValid pulse.
//
// state   | meaning
// IDLE    | waiting for startOfFrame
// RESOLVE | resolving ball k, one ball per cycle
// DONE    | results presented, resultValid high
module multi_ball_hit_controller #(
  parameter int NUM_BALLS    = 2,
  parameter int NUM_HOLES    = 6,
  parameter int VEL_W        = 11,
  parameter int TOP_OFFSET   = 0,
  parameter int DOWN_OFFSET  = 479,
  parameter int LEFT_OFFSET  = 0,
  parameter int RIGHT_OFFSET = 639,
  parameter int EDGE         = 8
) (
  input  logic                                   clk,
  input  logic                                   resetN,
  input  logic                                   startOfFrame,
  input  logic [10:0]                            pixelX,
  input  logic [10:0]                            pixelY,
  input  logic [NUM_BALLS-1:0]                   ballDR,
  input  logic                                   bordersDR,
  input  logic [NUM_HOLES-1:0]                   holeDR,
  input  logic [NUM_BALLS*VEL_W-1:0]             ballVelX,
  input  logic [NUM_BALLS*VEL_W-1:0]             ballVelY,
  output logic [NUM_BALLS*VEL_W-1:0]             ballVelXOut,
  output logic [NUM_BALLS*VEL_W-1:0]             ballVelYOut,
  output logic [NUM_BALLS-1:0]                   collisionOccurred,
  output logic [NUM_BALLS-1:0]                   holeHit,
  output logic [NUM_BALLS*$clog2(NUM_HOLES)-1:0] holeNum,
  output logic                                   resultValid,
  output logic [7:0]                             overrunCount
);

  localparam int HW = $clog2(NUM_HOLES);
  localparam int KW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [KW-1:0] LAST = KW'(NUM_BALLS - 1);
  localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VMIN = {1'b1, {(VEL_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;
  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic done_ok;

  // sticky evidence for the frame being scanned (side: 1 = right/bottom)
  logic [NUM_BALLS-1:0] hit_x, side_x, hit_y, side_y, hole_f, bb_f;
  logic [HW-1:0] hole_idx [NUM_BALLS];
  logic [KW-1:0] partner  [NUM_BALLS];
  // snapshot of the previous frame, consumed by the resolver
  logic [NUM_BALLS-1:0] s_hit_x, s_side_x, s_hit_y, s_side_y, s_hole, s_bb;
  logic [HW-1:0] s_hole_idx [NUM_BALLS];
  logic [KW-1:0] s_partner  [NUM_BALLS];
  logic signed [VEL_W-1:0] s_vx [NUM_BALLS];
  logic signed [VEL_W-1:0] s_vy [NUM_BALLS];
  // results being built (w_) and results last published (h_)
  logic signed [VEL_W-1:0] w_vx [NUM_BALLS];
  logic signed [VEL_W-1:0] w_vy [NUM_BALLS];
  logic signed [VEL_W-1:0] h_vx [NUM_BALLS];
  logic signed [VEL_W-1:0] h_vy [NUM_BALLS];
  logic [NUM_BALLS-1:0] w_col, w_hole, h_col, h_hole;
  logic [HW-1:0] w_hn [NUM_BALLS];
  logic [HW-1:0] h_hn [NUM_BALLS];

  logic x_left, x_right, y_top, y_bot, hole_any;
  logic [HW-1:0] hole_low;
  logic [NUM_BALLS-1:0] pair_any;
  logic [KW-1:0] pair_low [NUM_BALLS];

  logic signed [VEL_W-1:0] res_vx, res_vy;
  logic res_col, res_hole, flip_x, flip_y;
  logic [HW-1:0] res_hn;

  function automatic logic signed [VEL_W-1:0] sat_neg(input logic signed [VEL_W-1:0] v);
    return (v == VMIN) ? VMAX : -v;
  endfunction

  assign x_left   = bordersDR && (int'(pixelX) < LEFT_OFFSET + EDGE);
  assign x_right  = bordersDR && (int'(pixelX) > RIGHT_OFFSET - EDGE);
  assign y_top    = bordersDR && (int'(pixelY) < TOP_OFFSET + EDGE);
  assign y_bot    = bordersDR && (int'(pixelY) > DOWN_OFFSET - EDGE);
  assign hole_any = |holeDR;

  // lowest active hole and lowest other ball drawn on this pixel
  always_comb begin
    hole_low = '0;
    for (int h = NUM_HOLES - 1; h >= 0; h--)
      if (holeDR[h]) hole_low = HW'(h);
    for (int i = 0; i < NUM_BALLS; i++) begin
      pair_any[i] = 1'b0;
      pair_low[i] = '0;
      for (int j = NUM_BALLS - 1; j >= 0; j--)
        if (j != i && ballDR[j]) begin
          pair_any[i] = 1'b1;
          pair_low[i] = KW'(j);
        end
    end
  end

  // collect sticky evidence; snapshot and clear it at each frame start
  always_ff @(posedge clk) begin
    if (!resetN) begin
      {hit_x, side_x, hit_y, side_y, hole_f, bb_f} <= '0;
      {s_hit_x, s_side_x, s_hit_y, s_side_y, s_hole, s_bb} <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        hole_idx[i] <= '0; partner[i] <= '0;
        s_hole_idx[i] <= '0; s_partner[i] <= '0;
        s_vx[i] <= '0; s_vy[i] <= '0;
      end
    end else if (startOfFrame) begin
      {s_hit_x, s_side_x, s_hit_y, s_side_y, s_hole, s_bb} <=
        {hit_x, side_x, hit_y, side_y, hole_f, bb_f};
      {hit_x, side_x, hit_y, side_y, hole_f, bb_f} <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        s_hole_idx[i] <= hole_idx[i];
        s_partner[i]  <= partner[i];
        s_vx[i] <= ballVelX[i*VEL_W +: VEL_W];
        s_vy[i] <= ballVelY[i*VEL_W +: VEL_W];
      end
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (ballDR[i]) begin
          if (x_left || x_right) begin hit_x[i] <= 1'b1; side_x[i] <= x_right; end
          if (y_top || y_bot)    begin hit_y[i] <= 1'b1; side_y[i] <= y_bot;   end
          if (hole_any && !hole_f[i]) begin hole_f[i] <= 1'b1; hole_idx[i] <= hole_low; end
          if (pair_any[i] && !bb_f[i]) begin bb_f[i] <= 1'b1; partner[i] <= pair_low[i]; end
        end
      end
    end
  end

  // resolve ball k from the snapshot
  always_comb begin
    res_vx   = s_vx[k];
    res_vy   = s_vy[k];
    res_col  = 1'b0;
    res_hole = 1'b0;
    res_hn   = '0;
    flip_x   = s_hit_x[k] && (s_side_x[k] ? (s_vx[k] > 0) : (s_vx[k] < 0));
    flip_y   = s_hit_y[k] && (s_side_y[k] ? (s_vy[k] > 0) : (s_vy[k] < 0));
    if (s_hole[k]) begin
      res_vx = '0; res_vy = '0; res_hole = 1'b1; res_hn = s_hole_idx[k];
    end else if (s_bb[k]) begin
      res_vx = s_vx[s_partner[k]]; res_vy = s_vy[s_partner[k]]; res_col = 1'b1;
    end else begin
      if (flip_x) res_vx = sat_neg(s_vx[k]);
      if (flip_y) res_vy = sat_neg(s_vy[k]);
      res_col = flip_x | flip_y;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state; a frame start anywhere restarts the resolve
  always_comb begin
    state_nxt = state;
    if (startOfFrame) state_nxt = RESOLVE;
    else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RESOLVE: if (k == LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs; an aborting frame start suppresses the DONE pulse
  always_comb begin
    done_ok     = resetN && (state == DONE) && !startOfFrame;
    resultValid = done_ok;
  end

  // ball index, overrun counter, working and published result registers
  always_ff @(posedge clk) begin
    if (!resetN) begin
      k <= '0;
      overrunCount <= '0;
      {w_col, w_hole, h_col, h_hole} <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        w_vx[i] <= '0; w_vy[i] <= '0; w_hn[i] <= '0;
        h_vx[i] <= '0; h_vy[i] <= '0; h_hn[i] <= '0;
      end
    end else begin
      if (startOfFrame) begin
        k <= '0;
        if (state != IDLE && overrunCount != 8'hFF) overrunCount <= overrunCount + 8'd1;
      end else if (state == RESOLVE) begin
        k <= k + 1'b1;
        w_vx[k] <= res_vx; w_vy[k] <= res_vy; w_hn[k] <= res_hn;
        w_col[k] <= res_col; w_hole[k] <= res_hole;
      end
      if (done_ok) begin
        h_col <= w_col; h_hole <= w_hole;
        for (int i = 0; i < NUM_BALLS; i++) begin
          h_vx[i] <= w_vx[i]; h_vy[i] <= w_vy[i]; h_hn[i] <= w_hn[i];
        end
      end
    end
  end

  // present fresh results during the valid cycle, held results otherwise
  always_comb begin
    collisionOccurred = done_ok ? w_col  : h_col;
    holeHit           = done_ok ? w_hole : h_hole;
    for (int i = 0; i < NUM_BALLS; i++) begin
      ballVelXOut[i*VEL_W +: VEL_W] = done_ok ? w_vx[i] : h_vx[i];
      ballVelYOut[i*VEL_W +: VEL_W] = done_ok ? w_vy[i] : h_vy[i];
      holeNum[i*HW +: HW]           = done_ok ? w_hn[i] : h_hn[i];
    end
  end

endmodule

// File: doc/multi_ball_hit_controller.md
MULTI_BALL_HIT_CONTROLLER -- requirements
Module: multi_ball_hit_controller

Interface
REQ-001 Parameters SHALL be: NUM_BALLS, default 2, number of balls; NUM_HOLES, default 6, number of holes; VEL_W, default 11, signed velocity width; TOP_OFFSET, default 0, DOWN_OFFSET, default 479, LEFT_OFFSET, default 0, RIGHT_OFFSET, default 639, table edges in pixels; EDGE, default 8, side-classification margin in pixels.
REQ-002 The module SHALL have one clock and a synchronous, active-low reset.
REQ-003 Ports SHALL be:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
pixelX, pixelY  in  11 each  current scan pixel
ballDR  in  NUM_BALLS  per-ball draw request
bordersDR  in  1  border draw request
holeDR  in  NUM_HOLES  per-hole draw request
ballVelX, ballVelY  in  NUM_BALLS*VEL_W each  packed signed ball velocities, ball 0 in LSBs
ballVelXOut, ballVelYOut  out  NUM_BALLS*VEL_W each  packed resolved velocities
collisionOccurred  out  NUM_BALLS  ball hit a border or another ball
holeHit  out  NUM_BALLS  ball entered a hole
holeNum  out  NUM_BALLS*$clog2(NUM_HOLES)  hole index per ball
resultValid  out  1  one-cycle pulse when the outputs update
overrunCount  out  8  saturating count of aborted resolves

Function
REQ-004 COLLECT (all states): each cycle, for each ball i with ballDR[i]=1, the block SHALL set sticky flags:
- hitX[i] if bordersDR=1 and (pixelX < LEFT_OFFSET+EDGE or pixelX > RIGHT_OFFSET-EDGE)
- hitY[i] if bordersDR=1 and (pixelY < TOP_OFFSET+EDGE or pixelY > DOWN_OFFSET-EDGE)
- hole[i] plus holeIdx[i] = lowest set index of holeDR, if holeDR != 0 (the first hole recorded in the frame is kept)
- bb[i] plus partner[i] = lowest j != i with ballDR[j]=1 (the first partner recorded is kept)
REQ-005 On startOfFrame=1, the block SHALL:
- copy all sticky flags and ballVelX/Y into snapshot registers
- clear the sticky flags
- ignore the pixel on that cycle for collection
REQ-006 The FSM SHALL have states IDLE, RESOLVE and DONE; after reset it is in IDLE.
REQ-007 The FSM transitions SHALL be:
- IDLE to RESOLVE on startOfFrame, with index k=0
- in RESOLVE, ball k is processed and k increments each cycle; after k=NUM_BALLS-1 the FSM goes to DONE
- DONE to IDLE after one cycle, with resultValid=1 during DONE
REQ-008 The latency SHALL be: resultValid is high exactly NUM_BALLS+1 cycles after the startOfFrame cycle.
REQ-009 Priority per ball SHALL be hole > ball-ball > border > none.
REQ-010 Hole: the velocity output SHALL be 0, with holeHit=1, holeNum=holeIdx and collisionOccurred=0.
REQ-011 Ball-ball: the velocity output SHALL be the snapshot velocity of the partner, with collisionOccurred=1.
REQ-012 Border: X SHALL be negated only if hitX and the ball moves toward that wall (left wall and velX<0, or right wall and velX>0); Y SHALL follow the same rule for top and bottom; collisionOccurred=1 if any component flips.
REQ-013 To support REQ-012, the wall side SHALL be recorded with each sticky flag (left/right, top/bottom); if both sides were recorded in a frame, the most recent one SHALL win.
REQ-014 None: the output SHALL equal the snapshot velocity, with all flags 0.
REQ-015 Negation SHALL saturate: -2^(VEL_W-1) maps to 2^(VEL_W-1)-1.
REQ-016 Outputs SHALL update only in the cycle resultValid rises and hold until the next resultValid.
REQ-017 If startOfFrame arrives during RESOLVE or DONE, the block SHALL:
- abort the resolve
- re-snapshot per REQ-005
- restart RESOLVE at k=0
- increment overrunCount, saturating at 255
- not pulse resultValid for the aborted pass

Reset
REQ-018 When resetN=0 on a rising clk edge, the block SHALL, regardless of state:
- set all outputs to 0 (velocities, flags, holeNum, resultValid, overrunCount)
- clear sticky flags and snapshots
- set the FSM to IDLE
REQ-019 A startOfFrame coincident with resetN=0 SHALL be ignored.

Verification
REQ-020 Border: ball0 vel (+5,-3), ballDR0&bordersDR at pixel (636,200), then startOfFrame -> 3 cycles later resultValid=1, ball0 out (-5,-3), collisionOccurred=01.
REQ-021 Wall receding: ball0 vel (-5,0), hit at pixel (636,200) -> out (-5,0), collisionOccurred=0.
REQ-022 Ball-ball: ball0 (4,0) and ball1 (-2,1) drawn on the same pixel -> ball0 out (-2,1), ball1 out (4,0), collisionOccurred=11.
REQ-023 Hole over border: ball1 with holeDR=000100 and a border hit in the same frame -> ball1 out (0,0), holeHit=10, holeNum[1]=2, collisionOccurred[1]=0.
REQ-024 Saturation: ball0 velX=-1024 hits the left wall -> out velX=+1023.
REQ-025 Overrun and reset: startOfFrame at cycles 0 and 2 -> single resultValid at cycle 5, overrunCount=1; then resetN=0 for one cycle -> all outputs 0 and FSM in IDLE.
